// File: rtl/uart_rx_framer.sv
// uart_rx_framer: receive end of the UART link.
// Frame format: 1 start bit, DATA_WIDTH data bits (LSB first), optional
// even parity bit, 1 stop bit. Received bytes are offered on a valid/ack
// handshake together with framing, parity and overrun flags.
// Optional feature: define UART_RX_PARITY_EN to add the even-parity bit;
// without it the frame is 8N1 and parity_err is tied to 0.
module uart_rx_framer #(
    parameter int RX_CLK_FREQ = 50_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int DATA_WIDTH  = 8,
    parameter int OVERSAMPLE  = 16
) (
    input  logic                  rx_clk,
    input  logic                  reset,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] RxData,
    output logic                  rx_valid,
    input  logic                  rx_ack,
    output logic                  busy,
    output logic                  frame_err,
    output logic                  parity_err,
    output logic                  overrun
);
    localparam int DIV    = RX_CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int IDX_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                state;
    logic                  sync1;
    logic                  rs;
    logic                  rs_d;
    logic [DIV_W-1:0]      div_cnt;
    logic                  tick;
    logic [TICK_W-1:0]     tick_cnt;
    logic [TICK_W-1:0]     tick_limit;
    logic                  sample;
    logic [IDX_W-1:0]      bit_idx;
    logic [DATA_WIDTH-1:0] shift;
    logic                  pe;

    // Two-flop synchronizer on the serial line plus a delayed copy for start-edge detection.
    // Everything resets to the idle line level so release from reset never looks like a start edge.
    always_ff @(posedge rx_clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            rs    <= 1'b1;
            rs_d  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep each flop sampling the previous value of its source.
            sync1 <= rx;
            rs    <= sync1;
            rs_d  <= rs;
        end
    end

    // Sub-bit tick divider; held at zero while idle so the sampling phase follows the start edge.
    always_ff @(posedge rx_clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (state == IDLE || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick       = (state != IDLE) && (div_cnt == DIV_LAST);
    // The start bit is checked at its middle, every later bit one full bit period further on.
    assign tick_limit = (state == START) ? HALF_LAST : BIT_LAST;
    assign sample     = tick && (tick_cnt == tick_limit);

`ifndef UART_RX_PARITY_EN
    assign pe = 1'b0;
`endif

    // Frame FSM with registered handshake outputs and error flags.
    always_ff @(posedge rx_clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_idx    <= '0;
            shift      <= '0;
`ifdef UART_RX_PARITY_EN
            pe         <= 1'b0;
`endif
            RxData     <= '0;
            rx_valid   <= 1'b0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (state == IDLE || sample) begin
                tick_cnt <= '0;
            end else if (tick) begin
                tick_cnt <= tick_cnt + 1'b1;
            end

            // NOTE: the ack clear is written first; a commit further down in this block
            // assigns the same registers later and therefore wins in that cycle.
            if (rx_valid && rx_ack) begin
                rx_valid   <= 1'b0;
                frame_err  <= 1'b0;
                parity_err <= 1'b0;
                overrun    <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (rs_d && !rs) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (sample) begin
                        if (!rs) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            // Line went back high before mid start bit: a glitch, not a frame.
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (sample) begin
                        shift <= {rs, shift[DATA_WIDTH-1:1]};
                        if (bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (sample) begin
                        pe    <= (^shift) ^ rs;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (sample) begin
                        // Commit and return to IDLE together so a back-to-back start edge is caught.
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (!rx_valid || rx_ack) begin
                            RxData     <= shift;
                            rx_valid   <= 1'b1;
                            frame_err  <= !rs;
                            parity_err <= pe;
                            overrun    <= 1'b0;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_framer.sv
// tb_uart_rx_framer: self-checking bench for uart_rx_framer.
// Frames are driven bit by bit on rx; a transaction-level model of the
// valid/ack/overrun rules predicts every output. Define UART_RX_PARITY_EN
// for both bench and design to cover the parity build.
`timescale 1ns/1ps
module tb_uart_rx_framer;
    localparam int CLK_HZ  = 50_000_000;
    localparam int BAUD    = 115_200;
    localparam int OS      = 16;
    localparam int BIT     = (CLK_HZ / (BAUD * OS)) * OS;
    localparam int TICK    = CLK_HZ / (BAUD * OS);
`ifdef UART_RX_PARITY_EN
    localparam int NBITS   = 11;
`else
    localparam int NBITS   = 10;
`endif
    // Start edge to rx_valid: 2 sync cycles + everything up to mid stop bit.
    localparam int LAT_NOM = 2 + (NBITS - 1) * BIT + BIT / 2;

    logic       rx_clk;
    logic       reset;
    logic       rx;
    logic [7:0] RxData;
    logic       rx_valid;
    logic       rx_ack;
    logic       busy;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;

    int n_vec = 0;
    int n_err = 0;
    int lat   = 0;

    // Transaction-level model of the output handshake.
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_fe;
    logic       m_pe;
    logic       m_ov;

    uart_rx_framer dut (
        .rx_clk     (rx_clk),
        .reset      (reset),
        .rx         (rx),
        .RxData     (RxData),
        .rx_valid   (rx_valid),
        .rx_ack     (rx_ack),
        .busy       (busy),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    initial rx_clk = 1'b0;
    always #10 rx_clk = ~rx_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic par_of(input logic [7:0] d);
        return ^d;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_fe    = 1'b0;
        m_pe    = 1'b0;
        m_ov    = 1'b0;
    endtask

    // A completed frame: delivered if the slot is free or acked that cycle, else dropped as overrun.
    task automatic model_frame(input logic [7:0] d, input logic stop, input logic par, input logic ack_now);
        if (!m_valid || ack_now) begin
            m_valid = 1'b1;
            m_data  = d;
            m_fe    = (stop == 1'b0);
`ifdef UART_RX_PARITY_EN
            m_pe    = (par != par_of(d));
`else
            m_pe    = 1'b0;
`endif
            m_ov    = 1'b0;
        end else begin
            m_ov = 1'b1;
        end
    endtask

    task automatic model_ack();
        if (m_valid) begin
            m_valid = 1'b0;
            m_fe    = 1'b0;
            m_pe    = 1'b0;
            m_ov    = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"},  rx_valid,   m_valid);
        check({tag, ".data"},   RxData,     m_data);
        check({tag, ".ferr"},   frame_err,  m_fe);
        check({tag, ".perr"},   parity_err, m_pe);
        check({tag, ".ovr"},    overrun,    m_ov);
        check({tag, ".busy"},   busy,       1'b0);
    endtask

    // Drives one whole frame starting at a falling clock edge; leaves the line idle high.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
        rx = 1'b0;
        repeat (BIT) @(negedge rx_clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT) @(negedge rx_clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = par;
        repeat (BIT) @(negedge rx_clk);
`endif
        rx = stop;
        repeat (BIT) @(negedge rx_clk);
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge rx_clk);
    endtask

    task automatic do_ack(input string tag);
        rx_ack = 1'b1;
        @(negedge rx_clk);
        rx_ack = 1'b0;
        model_ack();
        check_all(tag);
    endtask

    initial begin
        #1_900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       saw;
        logic [7:0] d;
        logic       stop;
        logic       par;

        rx     = 1'b1;
        rx_ack = 1'b0;
        reset  = 1'b0;
        model_reset();
        repeat (5) @(negedge rx_clk);
        check_all("reset");
        reset = 1'b1;
        idle(20);

        // Plain frame, latency and busy during reception.
        fork
            send_frame(8'h45, 1'b1, par_of(8'h45));
            begin
                lat = 0;
                while (!rx_valid && lat < LAT_NOM + 2 * BIT) begin
                    @(negedge rx_clk);
                    lat++;
                    if (lat == 2 * BIT) check("e.busy_mid", busy, 1'b1);
                end
            end
        join
        check("e.latency_in_window", (lat >= LAT_NOM - TICK - 1) && (lat <= LAT_NOM + TICK + 1), 1'b1);
        model_frame(8'h45, 1'b1, par_of(8'h45), 1'b0);
        check_all("e");
        do_ack("e.ack");

        // Short low glitch: busy pulses, nothing delivered, next frame fine.
        saw = 1'b0;
        rx  = 1'b0;
        for (int i = 0; i < 250; i++) begin
            if (i == 100) rx = 1'b1;
            @(negedge rx_clk);
            if (busy) saw = 1'b1;
        end
        check("glitch.busy_pulse", saw, 1'b1);
        check_all("glitch");
        idle(20);
        send_frame(8'h4E, 1'b1, par_of(8'h4E));
        model_frame(8'h4E, 1'b1, par_of(8'h4E), 1'b0);
        check_all("n");
        do_ack("n.ack");

        // Stop bit driven low: delivered with frame_err.
        send_frame(8'h52, 1'b0, par_of(8'h52));
        model_frame(8'h52, 1'b0, par_of(8'h52), 1'b0);
        check_all("r.stop0");
        do_ack("r.ack");
        idle(30);

        // Back-to-back frames without ack: second one is an overrun.
        send_frame(8'h49, 1'b1, par_of(8'h49));
        send_frame(8'h51, 1'b1, par_of(8'h51));
        model_frame(8'h49, 1'b1, par_of(8'h49), 1'b0);
        model_frame(8'h51, 1'b1, par_of(8'h51), 1'b0);
        check_all("b2b.noack");
        do_ack("b2b.noack.ack");
        idle(30);

        // Same pair, with the ack landing exactly on the second commit cycle.
        fork
            begin
                send_frame(8'h49, 1'b1, par_of(8'h49));
                send_frame(8'h51, 1'b1, par_of(8'h51));
            end
            begin
                repeat (NBITS * BIT + lat - 1) @(negedge rx_clk);
                rx_ack = 1'b1;
                @(negedge rx_clk);
                rx_ack = 1'b0;
            end
        join
        model_frame(8'h49, 1'b1, par_of(8'h49), 1'b0);
        model_frame(8'h51, 1'b1, par_of(8'h51), 1'b1);
        check_all("b2b.ackcommit");
        do_ack("b2b.ackcommit.ack");
        idle(30);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h51, 1'b1, 1'b1);
        model_frame(8'h51, 1'b1, 1'b1, 1'b0);
        check_all("par.good");
        do_ack("par.good.ack");
        idle(30);
        send_frame(8'h51, 1'b1, 1'b0);
        model_frame(8'h51, 1'b1, 1'b0, 1'b0);
        check_all("par.bad");
        do_ack("par.bad.ack");
        idle(30);
`endif

        // Random frames: random data, stop/parity errors and ack decisions.
        // The last frame is never acked so the reset test starts with rx_valid set.
        for (int k = 0; k < 5; k++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            par  = par_of(d) ^ ($urandom_range(0, 2) == 0);
            send_frame(d, stop, par);
            model_frame(d, stop, par, 1'b0);
            check_all($sformatf("rand%0d", k));
            if (k < 4 && $urandom_range(0, 1) == 1) do_ack($sformatf("rand%0d.ack", k));
            idle(int'($urandom_range(10, 100)));
        end

        // Reset in the middle of data bit 4: everything clears at once.
        fork
            send_frame(8'h55, 1'b1, par_of(8'h55));
            begin
                repeat (5 * BIT + BIT / 2) @(negedge rx_clk);
                check("rst.busy_before", busy, 1'b1);
                reset = 1'b0;
                #1;
                model_reset();
                check_all("rst.async");
            end
        join
        idle(10);
        reset = 1'b1;
        idle(20);
        check_all("rst.after");
        send_frame(8'h45, 1'b1, par_of(8'h45));
        model_frame(8'h45, 1'b1, par_of(8'h45), 1'b0);
        check_all("rst.e");
        do_ack("rst.e.ack");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
